// File: rtl/mod_updown_counter.sv
// Modulo-(MAX_VAL+1) up/down counter with load, one-shot stop, and a registered wrap pulse.
// Optional 16-bit saturating wrap counter output when MOD_UPDOWN_COUNTER_WRAPCNT_EN is defined.
module mod_updown_counter #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned MAX_VAL  = (2**WIDTH) - 1,
   parameter int unsigned INIT_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             up_dn,
   input  logic             one_shot,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
`ifdef MOD_UPDOWN_COUNTER_WRAPCNT_EN
   output logic [15:0]      wrap_cnt,
`endif
   output logic             done
);

   localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] INIT_C = WIDTH'(INIT_VAL);
   localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             done_q, done_d;

   assign tc = up_dn ? (count_q == MAX_C) : (count_q == '0);

   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      done_d  = done_q;
      if (clr) begin
         count_d = '0;
         done_d  = 1'b0;
      end else if (load) begin
         count_d = (load_val > MAX_C) ? MAX_C : load_val;
         done_d  = 1'b0;
      end else if (en && !done_q) begin
         if (tc) begin
            // At terminal: one-shot parks here, free-run wraps to the opposite end.
            if (one_shot) begin
               done_d = 1'b1;
            end else begin
               count_d = up_dn ? '0 : MAX_C;
               wrap_d  = 1'b1;
            end
         end else begin
            count_d = up_dn ? (count_q + ONE_C) : (count_q - ONE_C);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= INIT_C;
         wrap_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
         done_q  <= done_d;
      end
   end

   assign count = count_q;
   assign wrap  = wrap_q;
   assign done  = done_q;

`ifdef MOD_UPDOWN_COUNTER_WRAPCNT_EN
   logic [15:0] wrap_cnt_q, wrap_cnt_d;

   // Counts on the same edge that raises wrap, so wrap_cnt and wrap move together.
   always_comb begin
      wrap_cnt_d = wrap_cnt_q;
      if (clr) begin
         wrap_cnt_d = '0;
      end else if (wrap_d && (wrap_cnt_q != 16'hFFFF)) begin
         wrap_cnt_d = wrap_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrap_cnt_q <= '0;
      end else begin
         wrap_cnt_q <= wrap_cnt_d;
      end
   end

   assign wrap_cnt = wrap_cnt_q;
`endif

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: two instances (INIT_VAL 0 and 3) share all stimulus.
module tb_mod_updown_counter;

   logic       clk;
   logic       rst;
   logic       en;
   logic       clr;
   logic       load;
   logic [3:0] load_val;
   logic       up_dn;
   logic       one_shot;

   logic [3:0] count0, count3;
   logic       tc0, tc3, wrap0, wrap3, done0, done3;
`ifdef MOD_UPDOWN_COUNTER_WRAPCNT_EN
   logic [15:0] wrap_cnt0, wrap_cnt3;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   int up_exp  [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
   int dn_exp  [4]  = '{1, 0, 9, 8};
   int dn_wrap [4]  = '{0, 0, 1, 0};
   int os_exp  [4]  = '{8, 9, 9, 9};
   int os_done [4]  = '{0, 0, 1, 1};

   mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .INIT_VAL(0)) dut0 (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .clr      (clr),
      .load     (load),
      .load_val (load_val),
      .up_dn    (up_dn),
      .one_shot (one_shot),
      .count    (count0),
      .tc       (tc0),
      .wrap     (wrap0),
`ifdef MOD_UPDOWN_COUNTER_WRAPCNT_EN
      .wrap_cnt (wrap_cnt0),
`endif
      .done     (done0)
   );

   mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .INIT_VAL(3)) dut3 (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .clr      (clr),
      .load     (load),
      .load_val (load_val),
      .up_dn    (up_dn),
      .one_shot (one_shot),
      .count    (count3),
      .tc       (tc3),
      .wrap     (wrap3),
`ifdef MOD_UPDOWN_COUNTER_WRAPCNT_EN
      .wrap_cnt (wrap_cnt3),
`endif
      .done     (done3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0;
      load_val = 4'd0; up_dn = 1'b1; one_shot = 1'b0;
      #1 rst = 1'b1;
      #1;
      n_checks++; if (count0 !== 4'd0) $display("FAIL reset_count0 got=%0d exp=0", count0); else n_pass++;
      n_checks++; if (count3 !== 4'd3) $display("FAIL reset_count3 got=%0d exp=3", count3); else n_pass++;
      n_checks++; if (wrap0 !== 1'b0 || done0 !== 1'b0) $display("FAIL reset_flags got wrap=%b done=%b exp 0 0", wrap0, done0); else n_pass++;
`ifdef MOD_UPDOWN_COUNTER_WRAPCNT_EN
      n_checks++; if (wrap_cnt0 !== 16'd0) $display("FAIL reset_wrap_cnt got=%0d exp=0", wrap_cnt0); else n_pass++;
`endif
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_count_up();
      up_dn = 1'b1;
      en    = 1'b1;
      for (int i = 0; i < 12; i++) begin
         n_checks++; if (count0 !== 4'(up_exp[i])) $display("FAIL up_count[%0d] got=%0d exp=%0d", i, count0, up_exp[i]); else n_pass++;
         n_checks++; if (tc0 !== (up_exp[i] == 9)) $display("FAIL up_tc[%0d] got=%b exp=%b", i, tc0, up_exp[i] == 9); else n_pass++;
         n_checks++; if (wrap0 !== (i == 10)) $display("FAIL up_wrap[%0d] got=%b exp=%b", i, wrap0, i == 10); else n_pass++;
         tick();
      end
      en = 1'b0;
   endtask

   task automatic test_count_down();
      up_dn    = 1'b0;
      load     = 1'b1;
      load_val = 4'd2;
      tick();
      load = 1'b0;
      n_checks++; if (count0 !== 4'd2 || count3 !== 4'd2) $display("FAIL dn_load got=%0d/%0d exp=2", count0, count3); else n_pass++;
      en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++; if (count0 !== 4'(dn_exp[i])) $display("FAIL dn_count[%0d] got=%0d exp=%0d", i, count0, dn_exp[i]); else n_pass++;
         n_checks++; if (wrap0 !== 1'(dn_wrap[i])) $display("FAIL dn_wrap[%0d] got=%b exp=%0d", i, wrap0, dn_wrap[i]); else n_pass++;
         if (i == 1) begin
            n_checks++; if (tc0 !== 1'b1) $display("FAIL dn_tc_at_zero got=%b exp=1", tc0); else n_pass++;
         end
      end
      // direction flips and applies on the very next enabled edge
      up_dn = 1'b1;
      tick();
      n_checks++; if (count0 !== 4'd9) $display("FAIL dir_change got=%0d exp=9", count0); else n_pass++;
      n_checks++; if (tc0 !== 1'b1) $display("FAIL dir_change_tc got=%b exp=1", tc0); else n_pass++;
      en = 1'b0;
   endtask

   task automatic test_one_shot();
      one_shot = 1'b1;
      up_dn    = 1'b1;
      load     = 1'b1;
      load_val = 4'd7;
      tick();
      load = 1'b0;
      n_checks++; if (count0 !== 4'd7) $display("FAIL os_load got=%0d exp=7", count0); else n_pass++;
      en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++; if (count0 !== 4'(os_exp[i])) $display("FAIL os_count[%0d] got=%0d exp=%0d", i, count0, os_exp[i]); else n_pass++;
         n_checks++; if (done0 !== 1'(os_done[i])) $display("FAIL os_done[%0d] got=%b exp=%0d", i, done0, os_done[i]); else n_pass++;
         n_checks++; if (wrap0 !== 1'b0) $display("FAIL os_wrap[%0d] got=%b exp=0", i, wrap0); else n_pass++;
      end
      up_dn = 1'b0;
      tick();
      n_checks++; if (count0 !== 4'd9 || done0 !== 1'b1) $display("FAIL os_done_ignores_en got count=%0d done=%b exp 9 1", count0, done0); else n_pass++;
      clr = 1'b1;
      tick();
      clr = 1'b0; en = 1'b0; one_shot = 1'b0; up_dn = 1'b1;
      n_checks++; if (count0 !== 4'd0 || done0 !== 1'b0) $display("FAIL os_clr got count=%0d done=%b exp 0 0", count0, done0); else n_pass++;
   endtask

   task automatic test_load_priority();
      load     = 1'b1;
      load_val = 4'd15;
      tick();
      load = 1'b0;
      n_checks++; if (count0 !== 4'd9) $display("FAIL load_sat got=%0d exp=9", count0); else n_pass++;
      clr = 1'b1; load = 1'b1; en = 1'b1; load_val = 4'd4;
      tick();
      n_checks++; if (count0 !== 4'd0) $display("FAIL clr_over_load got=%0d exp=0", count0); else n_pass++;
      clr = 1'b0;
      tick();
      n_checks++; if (count0 !== 4'd4) $display("FAIL load_over_en got=%0d exp=4", count0); else n_pass++;
      load = 1'b0; en = 1'b0;
      tick();
      n_checks++; if (count0 !== 4'd4 || wrap0 !== 1'b0) $display("FAIL hold got count=%0d wrap=%b exp 4 0", count0, wrap0); else n_pass++;
   endtask

   task automatic test_async_reset();
      up_dn = 1'b1; load = 1'b1; load_val = 4'd4; en = 1'b1;
      tick();
      load = 1'b0;
      tick();
      n_checks++; if (count0 !== 4'd5 || count3 !== 4'd5) $display("FAIL ar_pre got=%0d/%0d exp=5", count0, count3); else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_checks++; if (count3 !== 4'd3) $display("FAIL ar_count3 got=%0d exp=3", count3); else n_pass++;
      n_checks++; if (count0 !== 4'd0) $display("FAIL ar_count0 got=%0d exp=0", count0); else n_pass++;
      n_checks++; if (done3 !== 1'b0 || wrap3 !== 1'b0) $display("FAIL ar_flags got done=%b wrap=%b exp 0 0", done3, wrap3); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      en  = 1'b0;
   endtask

   task automatic test_reset_while_done();
      one_shot = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 4'd9; en = 1'b1;
      tick();
      load = 1'b0;
      tick();
      n_checks++; if (done0 !== 1'b1 || done3 !== 1'b1) $display("FAIL rd_pre_done got=%b/%b exp=1", done0, done3); else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_checks++; if (done0 !== 1'b0 || done3 !== 1'b0) $display("FAIL rd_done got=%b/%b exp=0", done0, done3); else n_pass++;
      n_checks++; if (count3 !== 4'd3) $display("FAIL rd_count3 got=%0d exp=3", count3); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      one_shot = 1'b0;
      tick();
      n_checks++; if (count3 !== 4'd4 || count0 !== 4'd1) $display("FAIL rd_resume got=%0d/%0d exp=4/1", count3, count0); else n_pass++;
      en = 1'b0;
   endtask

`ifdef MOD_UPDOWN_COUNTER_WRAPCNT_EN
   task automatic test_wrap_cnt();
      clr = 1'b1;
      tick();
      clr = 1'b0; up_dn = 1'b1; en = 1'b1;
      repeat (30) tick();
      en = 1'b0;
      n_checks++; if (count0 !== 4'd0) $display("FAIL wc_count got=%0d exp=0", count0); else n_pass++;
      n_checks++; if (wrap_cnt0 !== 16'd3 || wrap_cnt3 !== 16'd3) $display("FAIL wc_three got=%0d/%0d exp=3", wrap_cnt0, wrap_cnt3); else n_pass++;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      n_checks++; if (wrap_cnt0 !== 16'd0) $display("FAIL wc_clr got=%0d exp=0", wrap_cnt0); else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_count_up();
      test_count_down();
      test_one_shot();
      test_load_priority();
      test_async_reset();
      test_reset_while_done();
`ifdef MOD_UPDOWN_COUNTER_WRAPCNT_EN
      test_wrap_cnt();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the counter width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MAX_VAL, default 2**WIDTH-1, giving the terminal count and modulus MAX_VAL+1 (legal range 1..2**WIDTH-1).
REQ-003 The block SHALL have parameter INIT_VAL, default 0, giving the count value after reset (legal range 0..MAX_VAL).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit: count enable.
REQ-007 The block SHALL have port clr, input, 1 bit: synchronous clear to 0.
REQ-008 The block SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-009 The block SHALL have port load_val, input, WIDTH bits: the value to load.
REQ-010 The block SHALL have port up_dn, input, 1 bit: count direction (1 = up, 0 = down).
REQ-011 The block SHALL have port one_shot, input, 1 bit: run mode (1 = stop at terminal, 0 = free-run wrap).
REQ-012 The block SHALL have port count, output, WIDTH bits: the current count.
REQ-013 The block SHALL have port tc, output, 1 bit: terminal-count indicator (combinational).
REQ-014 The block SHALL have port wrap, output, 1 bit: registered one-cycle wrap pulse.
REQ-015 The block SHALL have port done, output, 1 bit: registered one-shot completion flag.

Function
REQ-016 Per-edge priority SHALL be rst > clr > load > en; with none of these asserted, all state SHALL hold.
REQ-017 On clr, count SHALL become 0, done SHALL become 0 and wrap SHALL become 0.
REQ-018 On load, count SHALL become min(load_val, MAX_VAL) and done SHALL become 0.
REQ-019 On en with done=0 and up_dn=1: if count<MAX_VAL then count SHALL become count+1; if count==MAX_VAL then count SHALL become 0.
REQ-020 On en with done=0 and up_dn=0: if count>0 then count SHALL become count-1; if count==0 then count SHALL become MAX_VAL.
REQ-021 tc SHALL equal (up_dn and count==MAX_VAL) or (!up_dn and count==0), independent of en.
REQ-022 wrap SHALL be 1 for exactly the one cycle following an enabled step taken while tc=1 and one_shot=0, and 0 otherwise.
REQ-023 With one_shot=1, an enabled step taken while tc=1 SHALL leave count unchanged, set done=1 and not pulse wrap.
REQ-024 While done=1, en SHALL be ignored; only clr, load or rst SHALL clear done.
REQ-025 An up_dn change SHALL take effect on the next enabled edge, with no dead cycle.
REQ-026 All arithmetic SHALL be modulo MAX_VAL+1; count SHALL never exceed MAX_VAL.

Reset
REQ-027 Asserting rst SHALL immediately, without a clock edge, set count=INIT_VAL, wrap=0 and done=0, including mid-count and while done=1.
REQ-028 Counting SHALL resume on the first rising clk edge after rst deasserts.

Configuration
REQ-029 When macro MOD_UPDOWN_COUNTER_WRAPCNT_EN is defined, the block SHALL add output wrap_cnt (16 bits), which SHALL increment on each wrap pulse, saturate at 16'hFFFF, and be cleared by rst or clr.
REQ-030 When MOD_UPDOWN_COUNTER_WRAPCNT_EN is undefined, port wrap_cnt and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-031 The bench SHALL cover: WIDTH=4, MAX_VAL=9, up_dn=1, en=1 for 12 cycles from reset -> count 0..9,0,1; wrap=1 only in the cycle after 9->0; tc=1 while count=9.
REQ-032 The bench SHALL cover: MAX_VAL=9, up_dn=0, load load_val=2, then en for 4 cycles -> count 2,1,0,9,8; wrap pulses once after 0->9.
REQ-033 The bench SHALL cover: one_shot=1, up_dn=1, load 7, MAX_VAL=9, en held -> count 8,9,9,9; done=1 from the edge after count reaches 9 with en asserted; wrap stays 0; clr -> count=0, done=0.
REQ-034 The bench SHALL cover: load_val=15 with MAX_VAL=9 -> count=9; clr, load and en asserted together -> count=0.
REQ-035 The bench SHALL cover: rst asserted asynchronously mid-count (count=5) between clk edges, with INIT_VAL=3 -> count=3, done=0 and wrap=0 before the next edge.
REQ-036 The bench SHALL cover (with MOD_UPDOWN_COUNTER_WRAPCNT_EN defined): 3 full wraps -> wrap_cnt=3; then clr -> wrap_cnt=0.
